// File: rtl/dev_dumper_pkg.sv
// dev_dumper_pkg: shared packages for the RAM hex dumper
//   pkg_ram : RAM geometry (byte-address width)
//   pkg_io  : dumper FSM state enum and ASCII separator constants
package pkg_ram;
  localparam int RAM_AW = 16;
endpackage

package pkg_io;
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_HI,
    S_LO,
    S_SEP,
    S_DONE
  } state_t;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/dev_dumper_if.sv
// dev_dumper_if: dumper control, RAM read port and character output bundle
//   control : start, base_addr, len -> busy, done
//   ram     : ram_addr, ram_rd -> ram_rdata (one cycle later)
//   putc    : putc_en -> putc_push, putc_char
//   display : byte_val, byte_valid
//   slave modport is the dumper side, master modport the environment side
interface dev_dumper_if #(parameter int ADDR_W = pkg_ram::RAM_AW);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_rdata;
  logic              putc_en;
  logic              putc_push;
  logic [7:0]        putc_char;
  logic [7:0]        byte_val;
  logic              byte_valid;
  modport master (
    output start, base_addr, len, ram_rdata, putc_en,
    input  busy, done, ram_addr, ram_rd, putc_push, putc_char, byte_val, byte_valid
  );
  modport slave (
    input  start, base_addr, len, ram_rdata, putc_en,
    output busy, done, ram_addr, ram_rd, putc_push, putc_char, byte_val, byte_valid
  );
endinterface

// File: rtl/dev_dumper_nibble.sv
// nibble_to_ascii: 4-bit value to uppercase ASCII hex digit
//   i_nib  : nibble 0..15
//   o_char : '0'-'9' (0x30-0x39) or 'A'-'F' (0x41-0x46)
module nibble_to_ascii (
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);
  assign o_char = i_nib < 4'd10 ? {4'h3, i_nib} : 8'h37 + {4'h0, i_nib};
endmodule

// File: rtl/dev_dumper.sv
// dev_dumper: streams a RAM region as hex text lines into an IO output buffer
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dev_dumper_if slave (control, RAM read port, putc port, display)
module dev_dumper
  import pkg_io::*;
#(
  parameter int ADDR_W         = pkg_ram::RAM_AW,
  parameter int BYTES_PER_LINE = 16
) (
  input logic          clk,
  input logic          rst,
  dev_dumper_if.slave  bus
);
  localparam int CW = BYTES_PER_LINE > 1 ? $clog2(BYTES_PER_LINE) : 1;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;
  logic [CW-1:0]     r_col;
  logic [7:0]        r_byte;
  logic              r_valid;
  logic [3:0]        w_nib;
  logic [7:0]        w_hex;
  logic              w_nl;
  // r_rem counts bytes not yet read, so it is already zero while the last byte's separator is pending
  assign w_nl  = r_rem == '0 || r_col == CW'(BYTES_PER_LINE - 1);
  assign w_nib = r_state == S_HI ? r_byte[7:4] : r_byte[3:0];
  nibble_to_ascii u_hex (.i_nib(w_nib), .o_char(w_hex));
  assign bus.busy       = r_state != S_IDLE;
  assign bus.done       = r_state == S_DONE;
  assign bus.ram_rd     = r_state == S_READ;
  assign bus.ram_addr   = r_addr;
  assign bus.putc_push  = bus.putc_en && r_state inside {S_HI, S_LO, S_SEP};
  assign bus.putc_char  = r_state == S_SEP ? (w_nl ? ASCII_LF : ASCII_SP) :
                          r_state inside {S_HI, S_LO} ? w_hex : 8'h00;
  assign bus.byte_val   = r_byte;
  assign bus.byte_valid = r_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_col   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_addr  <= bus.base_addr;
          r_rem   <= bus.len;
          r_col   <= '0;
          r_valid <= 1'b0;
          r_state <= bus.len == '0 ? S_DONE : S_READ;
        end
        S_READ: begin
          r_addr  <= r_addr + 1'b1;
          r_rem   <= r_rem - 1'b1;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_byte  <= bus.ram_rdata;
          r_valid <= 1'b1;
          r_state <= S_HI;
        end
        S_HI: if (bus.putc_en) r_state <= S_LO;
        S_LO: if (bus.putc_en) r_state <= S_SEP;
        S_SEP: if (bus.putc_en) begin
          r_col   <= w_nl ? '0 : r_col + 1'b1;
          r_state <= r_rem == '0 ? S_DONE : S_READ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dev_dumper.sv
// tb_dev_dumper: directed scoreboard bench for dev_dumper
module tb_dev_dumper;
  localparam int BPL = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] mem [0:65535];
  logic [7:0] exp_q [$];
  int passed = 0;
  int failed = 0;
  int total  = 0;
  dev_dumper_if #(.ADDR_W(16)) bus ();
  dev_dumper #(.ADDR_W(16), .BYTES_PER_LINE(BPL)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dump(input logic [15:0] base, input int n, input bit stall, input string tag,
                      output int rd_k, output int done_k);
    string hx = "0123456789ABCDEF";
    logic [7:0] b;
    logic [7:0] pch;
    bit pstall;
    int reads, pushes, nexp;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      b = mem[16'(base + i)];
      exp_q.push_back(hx[b[7:4]]);
      exp_q.push_back(hx[b[3:0]]);
      exp_q.push_back((i == n - 1 || (i + 1) % BPL == 0) ? 8'h0A : 8'h20);
    end
    nexp = exp_q.size();
    @(negedge clk);
    bus.base_addr = base;
    bus.len = 17'(n);
    bus.start = 1'b1;
    bus.putc_en = 1'b1;
    #1 check({tag, "_idle_busy"}, bus.busy, 0);
    rd_k = -1; done_k = -1; reads = 0; pushes = 0; pstall = 0; pch = 0;
    for (int k = 1; k <= 20 * n + 20 && done_k < 0; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.putc_en = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (k == 1) check({tag, "_busy"}, bus.busy, 1);
      if (pstall && pch != 8'h00) check({tag, "_stall_char"}, bus.putc_char, pch);
      pstall = !bus.putc_en;
      pch = bus.putc_char;
      if (bus.ram_rd) begin
        if (rd_k < 0) rd_k = k;
        check({tag, "_addr"}, bus.ram_addr, 16'(base + reads));
        reads++;
      end
      if (bus.putc_push) begin
        pushes++;
        if (exp_q.size() == 0) check({tag, "_push_count"}, pushes, nexp);
        else check({tag, "_char"}, bus.putc_char, exp_q.pop_front());
      end
      if (bus.done) done_k = k;
    end
    check({tag, "_done_seen"}, done_k > 0, 1);
    check({tag, "_reads"}, reads, n);
    check({tag, "_pushes"}, pushes, nexp);
    check({tag, "_left"}, exp_q.size(), 0);
    if (n > 0) begin
      check({tag, "_bvalid"}, bus.byte_valid, 1);
      check({tag, "_bval"}, bus.byte_val, mem[16'(base + n - 1)]);
    end
    @(negedge clk);
    #1 check({tag, "_after_done"}, {bus.done, bus.busy}, 0);
  endtask

  initial begin
    int rd_k, done_k, act;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h00;
    mem[16'h0011] = 8'hAB;
    mem[16'h0012] = 8'h7F;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.putc_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_ctl", {bus.busy, bus.done, bus.ram_rd, bus.putc_push, bus.byte_valid}, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_char", bus.putc_char, 0);
    check("rst_bval", bus.byte_val, 0);
    @(negedge clk);
    rst = 1'b0;

    dump(16'h0010, 3, 1'b0, "basic", rd_k, done_k);
    check("basic_rd_k", rd_k, 1);
    check("basic_read_to_done", done_k - rd_k, 15);
    dump(16'h0100, 17, 1'b0, "line17", rd_k, done_k);
    dump(16'h0200, 40, 1'b1, "stall", rd_k, done_k);
    dump(16'h0300, 0, 1'b0, "len0", rd_k, done_k);
    check("len0_done_k", done_k, 1);
    dump(16'hFFFF, 2, 1'b0, "wrap", rd_k, done_k);
    check("wrap_read_to_done", done_k - rd_k, 10);

    @(negedge clk);
    bus.base_addr = 16'h0011;
    bus.len = 17'd3;
    bus.start = 1'b1;
    bus.putc_en = 1'b1;
    repeat (4) @(negedge clk) bus.start = 1'b0;
    #1 check("abort_lo_char", {bus.putc_push, bus.putc_char}, {1'b1, 8'h42});
    rst = 1'b1;
    bus.start = 1'b1;
    #1;
    check("abort_ctl", {bus.busy, bus.done, bus.ram_rd, bus.putc_push, bus.byte_valid}, 0);
    check("abort_addr", bus.ram_addr, 0);
    check("abort_char", bus.putc_char, 0);
    check("abort_bval", bus.byte_val, 0);
    @(negedge clk);
    #1 check("rst_beats_start", bus.busy, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    act = 0;
    repeat (5) begin
      @(negedge clk);
      #1 act += int'(bus.putc_push) + int'(bus.done) + int'(bus.busy) + int'(bus.ram_rd);
    end
    check("abort_quiet", act, 0);
    dump(16'h0010, 3, 1'b0, "post_rst", rd_k, done_k);
    check("post_rst_read_to_done", done_k - rd_k, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
